// File: rtl/pipelined_sign_mag_adder.sv
// Pipelined sign-magnitude adder with optional saturation and an overflow
// event counter.
//
// The full sign-magnitude add is resolved in the first stage. The remaining
// STAGES-1 registers carry the result forward. All stages advance together
// on a single global enable, so a stalled output freezes the whole pipe.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operand pair presented
//   in_ready   : pair accepted this cycle (out_ready || !out_valid)
//   in1, in2   : sign-magnitude operands (bit WIDTH-1 = sign)
//   sat_en     : saturate on overflow, sampled with the operands
//   out_valid  : result valid
//   out_ready  : consumer takes the result
//   sum        : sign-magnitude result
//   ovf        : overflow flag, qualified by out_valid
//   ovf_clr    : synchronous clear of ovf_count
//   ovf_count  : saturating count of delivered overflowing results
module pipelined_sign_mag_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int MW = WIDTH - 1;

  // Magnitude of a same-sign sum: the carry out of the magnitude field is
  // the overflow; saturation replaces the wrapped bits with all ones.
  function automatic logic [MW-1:0] sat_mag(input logic [WIDTH-1:0] wide,
                                            input logic             sat);
    if (wide[MW] && sat) return '1;
    return wide[MW-1:0];
  endfunction

  // Clear has priority over a counted transfer; the count sticks at max.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic             inc,
                                                input logic             clr);
    if (clr) return '0;
    if (inc && (cnt != '1)) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  logic [MW-1:0]    mag1, mag2, diff, mag_c;
  logic             sgn1, sgn2, sgn_c, a_ge_b, ovf_c;
  logic [WIDTH-1:0] wide_sum, sum_c;

  always_comb begin
    mag1     = in1[MW-1:0];
    mag2     = in2[MW-1:0];
    // A -0 operand behaves as +0, so it never forces a sign decision.
    sgn1     = in1[MW] & (|mag1);
    sgn2     = in2[MW] & (|mag2);
    wide_sum = {1'b0, mag1} + {1'b0, mag2};
    a_ge_b   = (mag1 >= mag2);
    diff     = a_ge_b ? (mag1 - mag2) : (mag2 - mag1);
    ovf_c    = 1'b0;
    mag_c    = diff;
    sgn_c    = a_ge_b ? sgn1 : sgn2;
    if (sgn1 == sgn2) begin
      ovf_c = wide_sum[MW];
      mag_c = sat_mag(wide_sum, sat_en);
      sgn_c = sgn1;
    end
    // Zero magnitude always leaves as +0.
    sum_c = {sgn_c & (|mag_c), mag_c};
  end

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] ovf_p;
  logic [WIDTH-1:0]  sum_p [STAGES];
  logic              advance;

  assign in_ready = out_ready || !out_valid;
  assign advance  = in_ready;

  // Stage 0 captures the resolved result; later stages shift on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      ovf_p <= '0;
      for (int i = 0; i < STAGES; i++) sum_p[i] <= '0;
    end else if (advance) begin
      vld_p[0] <= in_valid;
      ovf_p[0] <= ovf_c & in_valid;
      sum_p[0] <= sum_c;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
        ovf_p[i] <= ovf_p[i-1];
        sum_p[i] <= sum_p[i-1];
      end
    end
  end

  assign out_valid = vld_p[STAGES-1];
  assign ovf       = ovf_p[STAGES-1];
  assign sum       = sum_p[STAGES-1];

  // Output boundary: count overflowing results as they are delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_count <= '0;
    else        ovf_count <= cnt_next(ovf_count, out_valid && out_ready && ovf, ovf_clr);
  end

endmodule

// File: tb/tb_pipelined_sign_mag_adder.sv
// Testbench for pipelined_sign_mag_adder (WIDTH=32, STAGES=4). A second
// instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_pipelined_sign_mag_adder;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          sat_en = 1'b0;
  logic          out_ready = 1'b1;
  logic          ovf_clr = 1'b0;
  logic [W-1:0]  in1 = '0, in2 = '0;
  logic          in_ready, out_valid, ovf;
  logic [W-1:0]  sum;
  logic [15:0]   ovf_count;
  logic          in_ready2, out_valid2, ovf2;
  logic [W-1:0]  sum2;
  logic [1:0]    ovf_count2;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         o;
  } exp_t;

  exp_t        exp_q[$];
  int          n_out = 0;
  logic [15:0] m_cnt = '0;
  logic [1:0]  m_cnt2 = '0;

  always #5 clk = ~clk;

  pipelined_sign_mag_adder #(.WIDTH(W), .STAGES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .sat_en(sat_en), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .ovf(ovf), .ovf_clr(ovf_clr),
    .ovf_count(ovf_count));

  pipelined_sign_mag_adder #(.WIDTH(W), .STAGES(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in1(in1), .in2(in2), .sat_en(sat_en), .out_valid(out_valid2),
    .out_ready(out_ready), .sum(sum2), .ovf(ovf2), .ovf_clr(ovf_clr),
    .ovf_count(ovf_count2));

  // Reference: interpret operands as signed integers and add them.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sat);
    exp_t   r;
    longint ma, mb, t, m, lim;
    logic   neg;
    lim = 64'h7FFF_FFFF;
    ma  = longint'(a[W-2:0]);
    mb  = longint'(b[W-2:0]);
    t   = (a[W-1] ? -ma : ma) + (b[W-1] ? -mb : mb);
    neg = (t < 0);
    m   = neg ? -t : t;
    r.o = 1'b0;
    if (m > lim) begin
      r.o = 1'b1;
      m   = sat ? lim : (m % (lim + 1));
    end
    if (m == 0) neg = 1'b0;
    r.s = {neg, m[W-2:0]};
    return r;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       ;
      1:       r[W-2:0] = 31'h7FFF_FFFF - 31'($urandom_range(0, 15));
      2:       r[W-2:0] = 31'($urandom_range(0, 7));
      default: r[W-2:0] = '0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: sampled on the falling edge, when inputs and outputs are
  // stable for the upcoming rising edge.
  task automatic sb_monitor();
    exp_t e;
    logic xo, ov_exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_cnt  = '0;
        m_cnt2 = '0;
      end else begin
        tests++;
        if (in_ready !== (out_ready || !out_valid)) begin
          fails++;
          $display("FAIL sb_in_ready got %b want %b", in_ready, out_ready || !out_valid);
        end
        tests++;
        if (ovf_count !== m_cnt) begin
          fails++;
          $display("FAIL sb_ovf_count got %0d want %0d", ovf_count, m_cnt);
        end
        tests++;
        if (ovf_count2 !== m_cnt2) begin
          fails++;
          $display("FAIL sb_ovf_count2 got %0d want %0d", ovf_count2, m_cnt2);
        end
        xo     = out_valid && out_ready;
        ov_exp = 1'b0;
        if (xo) begin
          n_out++;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected_out got sum=%h want no output", sum);
          end else begin
            e      = exp_q.pop_front();
            ov_exp = e.o;
            if ((sum !== e.s) || (ovf !== e.o)) begin
              fails++;
              $display("FAIL sb_result got sum=%h ovf=%b want sum=%h ovf=%b", sum, ovf, e.s, e.o);
            end
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(in1, in2, sat_en));
        if (ovf_clr) begin
          m_cnt  = '0;
          m_cnt2 = '0;
        end else if (xo && ov_exp) begin
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          if (m_cnt2 != 2'd3)    m_cnt2 = m_cnt2 + 2'd1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests++;
    if ({out_valid, ovf, sum, ovf_count} !== '0) begin
      fails++;
      $display("FAIL reset_state got v=%b o=%b s=%h c=%0d want all 0", out_valid, ovf, sum, ovf_count);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    tick();
  endtask

  task automatic test_latency();
    in1 = 32'h0000_0005; in2 = 32'h0000_0003; sat_en = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_early got out_valid=%b want 0", out_valid);
    end
    tick();
    tests++;
    if ((out_valid !== 1'b1) || (sum !== 32'h0000_0008) || (ovf !== 1'b0)) begin
      fails++;
      $display("FAIL latency_result got v=%b sum=%h ovf=%b want v=1 sum=00000008 ovf=0", out_valid, sum, ovf);
    end
    tick();
  endtask

  task automatic test_directed();
    logic [W-1:0] a [7];
    logic [W-1:0] b [7];
    logic [W-1:0] e [7];
    logic         s [7];
    logic         o [7];
    a = '{32'h0000_0005, 32'h8000_0005, 32'h0000_0007, 32'h8000_0000,
          32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    b = '{32'h8000_0003, 32'h0000_0003, 32'h8000_0007, 32'h8000_0000,
          32'h0000_0001, 32'h0000_0001, 32'h8000_0001};
    e = '{32'h0000_0002, 32'h8000_0002, 32'h0000_0000, 32'h0000_0000,
          32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      in1 = a[i]; in2 = b[i]; sat_en = s[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 10 && !out_valid; c++) tick();
      tests++;
      if ((out_valid !== 1'b1) || (sum !== e[i]) || (ovf !== o[i])) begin
        fails++;
        $display("FAIL directed_%0d got v=%b sum=%h ovf=%b want v=1 sum=%h ovf=%b", i, out_valid, sum, ovf, e[i], o[i]);
      end
      tick();
    end
    tests++;
    if ((ovf_count !== 16'd3) || (ovf_count2 !== 2'd3)) begin
      fails++;
      $display("FAIL ovf_count_three got %0d/%0d want 3/3", ovf_count, ovf_count2);
    end
  endtask

  task automatic test_count_sat();
    for (int i = 0; i < 2; i++) begin
      in1 = 32'h7FFF_FFFF; in2 = 32'h0000_0001; sat_en = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 10 && !out_valid; c++) tick();
      tick();
    end
    tests++;
    if ((ovf_count !== 16'd5) || (ovf_count2 !== 2'd3)) begin
      fails++;
      $display("FAIL count_saturate got %0d/%0d want 5/3", ovf_count, ovf_count2);
    end
    in1 = 32'h8000_0010; in2 = 32'hFFFF_FFF0; sat_en = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 10 && !out_valid; c++) tick();
    tests++;
    if ((out_valid !== 1'b1) || (ovf !== 1'b1)) begin
      fails++;
      $display("FAIL clr_setup got v=%b ovf=%b want 1/1", out_valid, ovf);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tests++;
    if ((ovf_count !== 16'd0) || (ovf_count2 !== 2'd0) || (out_valid !== 1'b0)) begin
      fails++;
      $display("FAIL clr_wins got %0d/%0d v=%b want 0/0 v=0", ovf_count, ovf_count2, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a [8];
    logic [W-1:0] b [8];
    int idx, n0;
    for (int i = 0; i < 8; i++) begin
      a[i] = rand_op();
      b[i] = rand_op();
    end
    idx = 0;
    n0  = n_out;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (idx < 8);
      if (idx < 8) begin
        in1 = a[idx]; in2 = b[idx]; sat_en = idx[0];
      end
      #1;
      tests++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        fails++;
        $display("FAIL b2b_in_ready cyc %0d got %b want %b", cyc, in_ready, !(out_valid && !out_ready));
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests++;
    if ((n_out - n0 != 8) || (idx != 8) || (exp_q.size() != 0)) begin
      fails++;
      $display("FAIL b2b_count got out=%0d acc=%0d pend=%0d want 8/8/0", n_out - n0, idx, exp_q.size());
    end
  endtask

  task automatic test_random();
    int acc, n0;
    acc = 0;
    n0  = n_out;
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 31) == 0);
      sat_en    = $urandom_range(0, 1);
      in1       = rand_op();
      in2       = ($urandom_range(0, 5) == 0) ? {~in1[W-1], in1[W-2:0]} : rand_op();
      #1;
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    for (int c = 0; c < 20 && (exp_q.size() != 0); c++) tick();
    tests++;
    if ((n_out - n0 != acc) || (exp_q.size() != 0)) begin
      fails++;
      $display("FAIL random_drain got out=%0d pend=%0d want out=%0d pend=0", n_out - n0, exp_q.size(), acc);
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      in1 = 32'h7FFF_FFF0 + 32'(i); in2 = 32'h0000_0100; sat_en = 1'b1; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    tests++;
    if ((out_valid !== 1'b0) || (ovf_count !== 16'd0) || (ovf_count2 !== 2'd0) || (sum !== '0)) begin
      fails++;
      $display("FAIL midreset_clear got v=%b c=%0d/%0d s=%h want 0", out_valid, ovf_count, ovf_count2, sum);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in1 = 32'h0000_0001; in2 = 32'h0000_0001; sat_en = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL midreset_stale k=%0d got out_valid=%b want 0", k, out_valid);
      end
      tick();
    end
    tests++;
    if ((out_valid !== 1'b1) || (sum !== 32'h0000_0002) || (ovf !== 1'b0)) begin
      fails++;
      $display("FAIL midreset_new got v=%b sum=%h ovf=%b want v=1 sum=00000002 ovf=0", out_valid, sum, ovf);
    end
    repeat (2) tick();
  endtask

  initial begin
    fork
      sb_monitor();
    join_none
    test_reset();
    test_latency();
    test_directed();
    test_count_sat();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
